// File: rtl/sram_arbiter.sv
// sram_arbiter: sequencer and arbiter for the shared 32-bit asynchronous SRAM
// (two 16-bit chips, word addressed).
//
// Three requesters share the SRAM:
//   vid  - video refresh, read only, highest priority
//   cpu  - RISC5 CPU, read/write, round-robin with aux
//   aux  - auxiliary DMA port, read/write, round-robin with cpu
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   vid_req/adr/ack     video read request (level) and one-cycle ack
//   vid_rdata           video read data, valid with vid_ack, held until next video read
//   cpu_req/we/adr/ben/wdata, cpu_ack, cpu_stall   CPU request port
//   aux_req/we/adr/ben/wdata, aux_ack              DMA request port
//   rdata               cpu/aux read data, valid with the ack, held until next cpu/aux read
//   sram_cs_n/oe_n/we_n/ben_n/adr/dout/dout_en     registered SRAM pad controls
//   sram_din            data returned from the pad buffers
//
// Timing, request seen in IDLE at cycle 0: strobes active cycles 1..WAIT,
// read ack at WAIT+1, write ack at WAIT+2 (one recovery cycle holds the
// data bus after we_n rises). The ack cycle is IDLE, so another port can
// be granted in it; the acked port is masked there to avoid a double grant.
module sram_arbiter #(
  parameter int WAIT  = 2,
  parameter int ADR_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vid_req,
  input  logic [ADR_W-1:0] vid_adr,
  output logic             vid_ack,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [3:0]       cpu_ben,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_ack,
  output logic             cpu_stall,
  input  logic             aux_req,
  input  logic             aux_we,
  input  logic [ADR_W-1:0] aux_adr,
  input  logic [3:0]       aux_ben,
  input  logic [31:0]      aux_wdata,
  output logic             aux_ack,
  output logic [31:0]      rdata,
  output logic [31:0]      vid_rdata,
  output logic             sram_cs_n,
  output logic             sram_oe_n,
  output logic             sram_we_n,
  output logic [3:0]       sram_ben_n,
  output logic [ADR_W-1:0] sram_adr,
  output logic [31:0]      sram_dout,
  output logic             sram_dout_en,
  input  logic [31:0]      sram_din
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;
  typedef enum logic [1:0] {P_VID, P_CPU, P_AUX} port_t;

  state_t           r_state, w_state;
  port_t            r_port, w_port;
  logic [3:0]       r_cnt, w_cnt;
  logic             r_we, w_we;
  logic             r_rr, w_rr;
  logic             r_cs_n, w_cs_n;
  logic             r_oe_n, w_oe_n;
  logic             r_we_n, w_we_n;
  logic [3:0]       r_ben_n, w_ben_n;
  logic [ADR_W-1:0] r_adr, w_adr;
  logic [31:0]      r_dout, w_dout;
  logic             r_dout_en, w_dout_en;
  logic [31:0]      r_rdata, w_rdata;
  logic [31:0]      r_vid_rdata, w_vid_rdata;
  logic             r_vid_ack, w_vid_ack;
  logic             r_cpu_ack, w_cpu_ack;
  logic             r_aux_ack, w_aux_ack;

  // grant selection
  logic             w_vid_ok, w_cpu_ok, w_aux_ok;
  logic             w_grant;
  port_t            w_gnt_port;
  logic             w_gnt_we;
  logic [ADR_W-1:0] w_gnt_adr;
  logic [3:0]       w_gnt_ben;
  logic [31:0]      w_gnt_wdata;

  // A port acked this cycle still holds its req; mask it so the same
  // request is not granted a second time.
  always_comb begin
    w_vid_ok    = vid_req & ~r_vid_ack;
    w_cpu_ok    = cpu_req & ~r_cpu_ack;
    w_aux_ok    = aux_req & ~r_aux_ack;
    w_grant     = 1'b1;
    w_gnt_port  = P_VID;
    w_gnt_we    = 1'b0;
    w_gnt_adr   = vid_adr;
    w_gnt_ben   = 4'hF;
    w_gnt_wdata = '0;
    if (!w_vid_ok) begin
      if (w_cpu_ok && (!w_aux_ok || !r_rr)) begin
        w_gnt_port  = P_CPU;
        w_gnt_we    = cpu_we;
        w_gnt_adr   = cpu_adr;
        w_gnt_ben   = cpu_ben;
        w_gnt_wdata = cpu_wdata;
      end else if (w_aux_ok) begin
        w_gnt_port  = P_AUX;
        w_gnt_we    = aux_we;
        w_gnt_adr   = aux_adr;
        w_gnt_ben   = aux_ben;
        w_gnt_wdata = aux_wdata;
      end else begin
        w_grant = 1'b0;
      end
    end
  end

  // next-state / next-output
  always_comb begin
    w_state     = r_state;
    w_port      = r_port;
    w_cnt       = r_cnt;
    w_we        = r_we;
    w_rr        = r_rr;
    w_cs_n      = r_cs_n;
    w_oe_n      = r_oe_n;
    w_we_n      = r_we_n;
    w_ben_n     = r_ben_n;
    w_adr       = r_adr;
    w_dout      = r_dout;
    w_dout_en   = r_dout_en;
    w_rdata     = r_rdata;
    w_vid_rdata = r_vid_rdata;
    w_vid_ack   = 1'b0;
    w_cpu_ack   = 1'b0;
    w_aux_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state = S_ACCESS;
          w_port  = w_gnt_port;
          w_we    = w_gnt_we;
          w_adr   = w_gnt_adr;
          w_cs_n  = 1'b0;
          w_cnt   = 4'(WAIT - 1);
          // point rr away from the cpu/aux port just granted
          if (w_gnt_port == P_CPU)      w_rr = 1'b1;
          else if (w_gnt_port == P_AUX) w_rr = 1'b0;
          if (w_gnt_we) begin
            w_we_n    = 1'b0;
            w_ben_n   = ~w_gnt_ben;
            w_dout_en = 1'b1;
            w_dout    = w_gnt_wdata;
          end else begin
            w_oe_n  = 1'b0;
            w_ben_n = 4'h0;
          end
        end
      end
      S_ACCESS: begin
        if (r_cnt == 4'd0) begin
          if (r_we) begin
            w_we_n  = 1'b1;
            w_state = S_RECOVER;
          end else begin
            if (r_port == P_VID) begin
              w_vid_rdata = sram_din;
              w_vid_ack   = 1'b1;
            end else begin
              w_rdata   = sram_din;
              w_cpu_ack = (r_port == P_CPU);
              w_aux_ack = (r_port == P_AUX);
            end
            w_oe_n  = 1'b1;
            w_cs_n  = 1'b1;
            w_ben_n = 4'hF;
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt - 4'd1;
        end
      end
      S_RECOVER: begin
        // data was held one cycle past we_n rising; release the bus now
        w_dout_en = 1'b0;
        w_cs_n    = 1'b1;
        w_ben_n   = 4'hF;
        w_cpu_ack = (r_port == P_CPU);
        w_aux_ack = (r_port == P_AUX);
        w_state   = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_port      <= P_VID;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_rr        <= 1'b0;
      r_cs_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_ben_n     <= 4'hF;
      r_adr       <= '0;
      r_dout      <= '0;
      r_dout_en   <= 1'b0;
      r_rdata     <= '0;
      r_vid_rdata <= '0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_aux_ack   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_port      <= w_port;
      r_cnt       <= w_cnt;
      r_we        <= w_we;
      r_rr        <= w_rr;
      r_cs_n      <= w_cs_n;
      r_oe_n      <= w_oe_n;
      r_we_n      <= w_we_n;
      r_ben_n     <= w_ben_n;
      r_adr       <= w_adr;
      r_dout      <= w_dout;
      r_dout_en   <= w_dout_en;
      r_rdata     <= w_rdata;
      r_vid_rdata <= w_vid_rdata;
      r_vid_ack   <= w_vid_ack;
      r_cpu_ack   <= w_cpu_ack;
      r_aux_ack   <= w_aux_ack;
    end
  end

  assign vid_ack      = r_vid_ack;
  assign cpu_ack      = r_cpu_ack;
  assign aux_ack      = r_aux_ack;
  assign cpu_stall    = cpu_req & ~r_cpu_ack;
  assign rdata        = r_rdata;
  assign vid_rdata    = r_vid_rdata;
  assign sram_cs_n    = r_cs_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_ben_n   = r_ben_n;
  assign sram_adr     = r_adr;
  assign sram_dout    = r_dout;
  assign sram_dout_en = r_dout_en;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed transaction table, reset corner cases,
// WAIT=1/15 latency builds, and random traffic against a transaction-level
// timeline model with a behavioural SRAM.
module tb_sram_arbiter;
  localparam int WAIT = 2;
  localparam int AW   = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // main DUT signals
  logic          vid_req = 0, cpu_req = 0, cpu_we = 0, aux_req = 0, aux_we = 0;
  logic [AW-1:0] vid_adr = '0, cpu_adr = '0, aux_adr = '0;
  logic [3:0]    cpu_ben = '0, aux_ben = '0;
  logic [31:0]   cpu_wdata = '0, aux_wdata = '0;
  logic          vid_ack, cpu_ack, cpu_stall, aux_ack;
  logic [31:0]   rdata, vid_rdata, sram_dout, sram_din;
  logic          sram_cs_n, sram_oe_n, sram_we_n, sram_dout_en;
  logic [3:0]    sram_ben_n;
  logic [AW-1:0] sram_adr;

  sram_arbiter #(.WAIT(WAIT), .ADR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_ben(cpu_ben),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_adr(aux_adr), .aux_ben(aux_ben),
    .aux_wdata(aux_wdata), .aux_ack(aux_ack),
    .rdata(rdata), .vid_rdata(vid_rdata),
    .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ben_n(sram_ben_n), .sram_adr(sram_adr), .sram_dout(sram_dout),
    .sram_dout_en(sram_dout_en), .sram_din(sram_din)
  );

  // behavioural SRAM, 16 words aliased on the low address bits
  logic [31:0] smem [16];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else if (!sram_cs_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_ben_n[b]) smem[sram_adr[3:0]][b*8 +: 8] <= sram_dout[b*8 +: 8];
    end
  end
  assign sram_din = (!sram_cs_n && !sram_oe_n) ? smem[sram_adr[3:0]] : 32'h0BAD_0BAD;

  // WAIT=1 and WAIT=15 builds, CPU port only
  logic          t_req = 0, z1 = 0;
  logic [AW-1:0] z18 = '0;
  logic [3:0]    z4 = '0;
  logic [31:0]   z32 = '0, t_din = 32'h600D_F00D;
  logic          a_vack, a_cack, a_cst, a_aack, a_cs, a_oe, a_we, a_den;
  logic          b_vack, b_cack, b_cst, b_aack, b_cs, b_oe, b_we, b_den;
  logic [31:0]   a_rd, a_vrd, a_do, b_rd, b_vrd, b_do;
  logic [3:0]    a_bn, b_bn;
  logic [AW-1:0] a_ad, b_ad;

  sram_arbiter #(.WAIT(1), .ADR_W(AW)) dut_w1 (
    .clk(clk), .rst(rst), .vid_req(z1), .vid_adr(z18), .vid_ack(a_vack),
    .cpu_req(t_req), .cpu_we(z1), .cpu_adr(z18), .cpu_ben(z4), .cpu_wdata(z32),
    .cpu_ack(a_cack), .cpu_stall(a_cst), .aux_req(z1), .aux_we(z1), .aux_adr(z18),
    .aux_ben(z4), .aux_wdata(z32), .aux_ack(a_aack), .rdata(a_rd), .vid_rdata(a_vrd),
    .sram_cs_n(a_cs), .sram_oe_n(a_oe), .sram_we_n(a_we), .sram_ben_n(a_bn),
    .sram_adr(a_ad), .sram_dout(a_do), .sram_dout_en(a_den), .sram_din(t_din)
  );
  sram_arbiter #(.WAIT(15), .ADR_W(AW)) dut_w15 (
    .clk(clk), .rst(rst), .vid_req(z1), .vid_adr(z18), .vid_ack(b_vack),
    .cpu_req(t_req), .cpu_we(z1), .cpu_adr(z18), .cpu_ben(z4), .cpu_wdata(z32),
    .cpu_ack(b_cack), .cpu_stall(b_cst), .aux_req(z1), .aux_we(z1), .aux_adr(z18),
    .aux_ben(z4), .aux_wdata(z32), .aux_ack(b_aack), .rdata(b_rd), .vid_rdata(b_vrd),
    .sram_cs_n(b_cs), .sram_oe_n(b_oe), .sram_we_n(b_we), .sram_ben_n(b_bn),
    .sram_adr(b_ad), .sram_dout(b_do), .sram_dout_en(b_den), .sram_din(t_din)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    vid_req = 0; cpu_req = 0; aux_req = 0; cpu_we = 0; aux_we = 0; t_req = 0;
  endtask

  // leaves rst asserted at posedge+1, outputs already in reset state
  task automatic hold_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic          aux;
    logic          we;
    logic [AW-1:0] adr;
    logic [3:0]    ben;
    logic [31:0]   wdata;
    int            exp_ack;
    logic [31:0]   exp_rdata;
    logic [3:0]    exp_ben_n;
  } vec_t;

  task automatic run_vec(input int idx, input vec_t v);
    int ack_c = -1, oe_lo = 0, we_lo = 0, den = 0;
    logic [3:0] bn = 4'hF;
    logic [AW-1:0] a1 = '0;
    logic [31:0] d1 = '0, rd = '0;
    logic st1 = 1'b0, st_ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) begin
        if (v.aux) begin
          aux_req = 1; aux_we = v.we; aux_adr = v.adr; aux_ben = v.ben; aux_wdata = v.wdata;
        end else begin
          cpu_req = 1; cpu_we = v.we; cpu_adr = v.adr; cpu_ben = v.ben; cpu_wdata = v.wdata;
        end
      end
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n) we_lo++;
      if (sram_dout_en) den++;
      if (c == 1) begin bn = sram_ben_n; a1 = sram_adr; d1 = sram_dout; st1 = cpu_stall; end
      if (v.aux ? aux_ack : cpu_ack) begin
        ack_c = c; rd = rdata; st_ack = cpu_stall;
        cpu_req = 0; aux_req = 0;
        break;
      end
      tick();
    end
    if (ack_c < 0) begin cpu_req = 0; aux_req = 0; end
    chk($sformatf("vec%0d ack_cycle", idx), 64'(ack_c), 64'(v.exp_ack));
    chk($sformatf("vec%0d rdata", idx), 64'(rd), 64'(v.exp_rdata));
    chk($sformatf("vec%0d ben_n", idx), 64'(bn), 64'(v.exp_ben_n));
    chk($sformatf("vec%0d sram_adr", idx), 64'(a1), 64'(v.adr));
    chk($sformatf("vec%0d oe_low_cycles", idx), 64'(oe_lo), v.we ? 64'd0 : 64'(WAIT));
    chk($sformatf("vec%0d we_low_cycles", idx), 64'(we_lo), v.we ? 64'(WAIT) : 64'd0);
    chk($sformatf("vec%0d dout_en_cycles", idx), 64'(den), v.we ? 64'(WAIT + 1) : 64'd0);
    if (v.we) chk($sformatf("vec%0d sram_dout", idx), 64'(d1), 64'(v.wdata));
    if (!v.aux) begin
      chk($sformatf("vec%0d stall_waiting", idx), 64'(st1), 64'd1);
      chk($sformatf("vec%0d stall_at_ack", idx), 64'(st_ack), 64'd0);
    end
    tick();
  endtask

  // ---------------------------------------------------------- random model
  // Timeline model: the SRAM is free from the ack cycle of the previous
  // access; a grant at cycle t acks at t+WAIT+1 (read) or t+WAIT+2 (write).
  task automatic run_rand(input int ncyc, input int pv, input int pc, input int pa, input int pwr);
    logic [31:0]   mm [16];
    bit            act [3];
    bit            we [3];
    logic [AW-1:0] ad [3];
    logic [3:0]    bn [3];
    logic [31:0]   wd [3];
    bit            e [3];
    bit            got [3];
    int free_at = 0, exp_at = -1, exp_p = -1, sel;
    bit exp_we = 0, rr = 0;
    logic [31:0] exp_d = '0, last_rd = '0;
    int prob [3];
    prob[0] = pv; prob[1] = pc; prob[2] = pa;
    for (int i = 0; i < 16; i++) mm[i] = '0;
    for (int p = 0; p < 3; p++) begin act[p] = 0; we[p] = 0; ad[p] = '0; bn[p] = '0; wd[p] = '0; end
    for (int cyc = 0; cyc < ncyc + 60; cyc++) begin
      chk("we_oe_overlap", 64'(!sram_we_n && !sram_oe_n), 64'd0);
      chk("dout_en_oe_overlap", 64'(sram_dout_en && !sram_oe_n), 64'd0);
      got[0] = vid_ack; got[1] = cpu_ack; got[2] = aux_ack;
      for (int p = 0; p < 3; p++) begin
        e[p] = (exp_p == p) && (cyc == exp_at);
        if (got[p] || e[p]) chk($sformatf("ack port%0d cyc%0d", p, cyc), 64'(got[p]), 64'(e[p]));
        if (e[p]) begin
          if (p == 0) chk("vid_rdata", 64'(vid_rdata), 64'(exp_d));
          else if (!exp_we) begin chk("rdata", 64'(rdata), 64'(exp_d)); last_rd = exp_d; end
          else chk("rdata_hold", 64'(rdata), 64'(last_rd));
          act[p] = 0;
        end
      end
      if (cyc < ncyc) begin
        for (int p = 0; p < 3; p++)
          if (!act[p] && $urandom_range(0, 99) < prob[p]) begin
            act[p] = 1;
            we[p]  = (p != 0) && ($urandom_range(0, 99) < pwr);
            ad[p]  = AW'($urandom());
            bn[p]  = 4'($urandom());
            wd[p]  = $urandom();
          end
      end
      vid_req = act[0]; vid_adr = ad[0];
      cpu_req = act[1]; cpu_we = we[1]; cpu_adr = ad[1]; cpu_ben = bn[1]; cpu_wdata = wd[1];
      aux_req = act[2]; aux_we = we[2]; aux_adr = ad[2]; aux_ben = bn[2]; aux_wdata = wd[2];
      if (cyc >= free_at) begin
        sel = -1;
        if (act[0] && !e[0]) sel = 0;
        else if (act[1] && !e[1] && act[2] && !e[2]) sel = rr ? 2 : 1;
        else if (act[1] && !e[1]) sel = 1;
        else if (act[2] && !e[2]) sel = 2;
        if (sel >= 0) begin
          exp_p = sel; exp_we = we[sel];
          exp_at = cyc + WAIT + 1 + (exp_we ? 1 : 0);
          free_at = exp_at;
          if (sel == 1) rr = 1;
          if (sel == 2) rr = 0;
          if (exp_we) begin
            for (int b = 0; b < 4; b++)
              if (bn[sel][b]) mm[ad[sel][3:0]][b*8 +: 8] = wd[sel][b*8 +: 8];
          end else begin
            exp_d = mm[ad[sel][3:0]];
          end
        end
      end
      tick();
    end
    chk("drain_all_served", 64'({act[0], act[1], act[2]}), 64'd0);
    clear_inputs();
  endtask

  vec_t tbl [7];

  initial begin
    int a1c, a15c;
    tbl[0] = '{0, 1, 18'h00123, 4'hF, 32'hDEADBEEF, WAIT + 2, 32'h0,        4'h0};
    tbl[1] = '{0, 0, 18'h00123, 4'h0, 32'h0,        WAIT + 1, 32'hDEADBEEF, 4'h0};
    tbl[2] = '{0, 1, 18'h3FFFF, 4'b0010, 32'h11223344, WAIT + 2, 32'hDEADBEEF, 4'b1101};
    tbl[3] = '{1, 0, 18'h3FFFF, 4'h0, 32'h0,        WAIT + 1, 32'h00003300, 4'h0};
    tbl[4] = '{1, 1, 18'h00003, 4'hF, 32'hCAFEF00D, WAIT + 2, 32'h00003300, 4'h0};
    tbl[5] = '{1, 0, 18'h10013, 4'h0, 32'h0,        WAIT + 1, 32'hCAFEF00D, 4'h0};
    tbl[6] = '{0, 0, 18'h00005, 4'h0, 32'h0,        WAIT + 1, 32'h0,        4'h0};

    // reset state
    hold_reset();
    chk("rst cs/oe/we", 64'({sram_cs_n, sram_oe_n, sram_we_n}), 64'b111);
    chk("rst ben_n", 64'(sram_ben_n), 64'hF);
    chk("rst dout_en", 64'(sram_dout_en), 64'd0);
    chk("rst acks", 64'({vid_ack, cpu_ack, aux_ack}), 64'd0);
    chk("rst adr/dout", 64'({sram_adr, sram_dout}), 64'd0);
    chk("rst rdata", 64'({rdata, vid_rdata}), 64'd0);
    rst = 1'b1;

    // reset in the middle of an access
    cpu_req = 1; cpu_we = 0; cpu_adr = 18'h00007;
    tick();
    chk("midrst access active", 64'({sram_cs_n, sram_oe_n}), 64'b00);
    rst = 1'b0;
    tick();
    chk("midrst strobes", 64'({sram_cs_n, sram_oe_n, sram_we_n}), 64'b111);
    chk("midrst ben_n", 64'(sram_ben_n), 64'hF);
    chk("midrst ack", 64'(cpu_ack), 64'd0);
    cpu_req = 0; rst = 1'b1;
    a1c = 0;
    repeat (8) begin if (cpu_ack) a1c++; tick(); end
    chk("midrst no late ack", 64'(a1c), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // latency of WAIT=1 and WAIT=15 builds
    a1c = -1; a15c = -1;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) t_req = 1;
      if (a_cack && a1c < 0) a1c = c;
      if (b_cack && a15c < 0) begin a15c = c; t_req = 0; end
      tick();
    end
    t_req = 0;
    chk("wait1 ack cycle", 64'(a1c), 64'd2);
    chk("wait15 ack cycle", 64'(a15c), 64'd16);
    chk("wait1 rdata", 64'(a_rd), 64'h600DF00D);
    chk("wait15 rdata", 64'(b_rd), 64'h600DF00D);
    tick();

    // all three ports requesting continuously
    hold_reset(); rst = 1'b1;
    run_rand(300, 100, 100, 100, 50);
    // back-to-back cpu/aux writes
    hold_reset(); rst = 1'b1;
    run_rand(300, 0, 100, 100, 100);
    // mixed random traffic
    hold_reset(); rst = 1'b1;
    run_rand(2000, 20, 30, 30, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
